// File: rtl/product_accum_pkg.sv
// Shared types and widths for the product accumulator that sits behind the
// 4x4 array multiplier.
package product_accum_pkg;

  localparam int LEN_W  = 4;
  localparam int ACC_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums a programmed number of 8-bit products into a 16-bit accumulator and
// returns the sum as two bytes, low first, over a valid/ready byte channel.
module product_accumulator
  import product_accum_pkg::*;
#(
  parameter int LEN_W = product_accum_pkg::LEN_W,
  parameter int ACC_W = product_accum_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              busy,
  output logic              done
);

  // one extra bit so a length of 0 can hold the full 2^LEN_W count
  localparam int CNT_W = LEN_W + 1;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
            acc       <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc       <= acc + {{(ACC_W-BYTE_W){1'b0}}, in_prod};
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (out_ready) state <= SEND_HI;
        end
        SEND_HI: begin
          if (out_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // handshake outputs depend on state only, never on in_valid/out_ready
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == SEND_LO) || (state == SEND_HI);
  assign busy      = (state != IDLE);

  always_comb begin
    out_byte = '0;
    case (state)
      SEND_LO: out_byte = acc[BYTE_W-1:0];
      SEND_HI: out_byte = acc[2*BYTE_W-1:BYTE_W];
      default: out_byte = '0;
    endcase
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized bench for product_accumulator against a block-level sum model.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_prod;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int prods [16];

  product_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // advance one edge; everything after returns 1 time unit past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gap < 0: random 0..2 idle cycles before each product; lo_stall < 0: random
  task automatic run_block(input int n_len, input int gap, input int lo_stall,
                           input bit start_mid);
    int eff;
    int sum;
    int g;
    int s;
    eff = (n_len == 0) ? 16 : n_len;
    sum = 0;
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    start    = 1'b1;
    len      = n_len[3:0];
    in_valid = 1'b1;                 // must be ignored in IDLE
    in_prod  = 8'($urandom_range(1, 255));
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < eff; i++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int k = 0; k < g; k++) begin
        chk("accum_in_ready", in_ready, 1);
        start   = start_mid;         // must be ignored outside IDLE
        in_prod = 8'($urandom);
        step();
      end
      start = 1'b0;
      chk("accum_in_ready", in_ready, 1);
      chk("accum_busy", busy, 1);
      chk("accum_out_valid", out_valid, 0);
      in_valid = 1'b1;
      in_prod  = prods[i][7:0];
      sum     += prods[i];
      if (start_mid) start = 1'b1;
      step();
      in_valid = 1'b0;
      start    = 1'b0;
    end
    s = (lo_stall < 0) ? $urandom_range(0, 3) : lo_stall;
    out_ready = 1'b0;
    for (int k = 0; k <= s; k++) begin
      chk("lo_in_ready", in_ready, 0);
      chk("lo_out_valid", out_valid, 1);
      chk("lo_byte", out_byte, 16'(sum & 8'hFF));
      chk("lo_done", done, 0);
      if (k == s) out_ready = 1'b1;
      step();
    end
    s = $urandom_range(0, 2);
    out_ready = (s == 0);
    for (int k = 0; k <= s; k++) begin
      chk("hi_out_valid", out_valid, 1);
      chk("hi_byte", out_byte, 16'((sum >> 8) & 8'hFF));
      chk("hi_busy", busy, 1);
      if (k == s) out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_out_valid", out_valid, 0);
    chk("done_out_byte", out_byte, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    // 3 x 225 = 675 -> 0xA3, 0x02
    for (int i = 0; i < 16; i++) prods[i] = 225;
    run_block(3, 0, 0, 1'b0);
    // len 0 -> 16 x 225 = 3600 -> 0x10, 0x0E, back-to-back start in done cycle
    run_block(0, 0, 0, 1'b0);
    // 0xFF + 0x01 with 2-cycle gaps -> 0x00, 0x01
    prods[0] = 255; prods[1] = 1;
    run_block(2, 2, 0, 1'b0);
    // low byte held while out_ready is low
    for (int i = 0; i < 16; i++) prods[i] = 225;
    run_block(3, 0, 3, 1'b0);
    // start pulsed throughout ACCUM
    for (int i = 0; i < 16; i++) prods[i] = 10 + i;
    run_block(5, 1, 0, 1'b1);

    // reset mid-block after 2 of 4 products
    start = 1'b1; len = 4'd4; step(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_prod = 8'd200; step();
    end
    in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_out_valid", out_valid, 0);
    step();
    prods[0] = 7;
    run_block(1, 0, 0, 1'b0);

    // random blocks
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 16; i++) prods[i] = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) step();
      run_block($urandom_range(0, 15), -1, -1, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
